// File: rtl/jt6295_pkg.sv
// -----------------------------------------------------------------------------
// jt6295_pkg
// Shared constants and types for the JT6295 ROM arbiter slice.
//   NUM_CH   : number of ADPCM channel requesters (fixed at 4)
//   AW       : external ROM byte-address width (fixed at 18)
//   NUM_REQ  : total requesters (channels + control block)
//   CTRL_IDX : requester index used for the control block
//   arb_state_t : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package jt6295_pkg;

    localparam int NUM_CH  = 4;
    localparam int AW      = 18;
    localparam int NUM_REQ = NUM_CH + 1;

    // Requesters 0..3 are the channels, 4 is the control block.
    typedef logic [2:0] req_idx_t;
    localparam req_idx_t CTRL_IDX = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Channel index that follows ch, wrapping ch3 -> ch0.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/jt6295_rom_arb_if.sv
// -----------------------------------------------------------------------------
// jt6295_rom_arb_if
// External ROM bus seen by the arbiter.
//   rom_addr : byte address driven by the arbiter
//   rom_cs   : request, high while an access is outstanding
//   rom_data : byte returned by the ROM
//   rom_ok   : rom_data valid for the current rom_addr
// Modports: master = arbiter side, slave = ROM side.
// -----------------------------------------------------------------------------
interface jt6295_rom_arb_if;
    import jt6295_pkg::*;

    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;

    modport master (
        output rom_addr,
        output rom_cs,
        input  rom_data,
        input  rom_ok
    );

    modport slave (
        input  rom_addr,
        input  rom_cs,
        output rom_data,
        output rom_ok
    );

endinterface

// File: rtl/jt6295_rr_pick.sv
// -----------------------------------------------------------------------------
// jt6295_rr_pick
// Round-robin picker over the four channel requesters. The search starts at
// the channel after last_i and wraps ch3 -> ch0; the first pending channel
// found is returned.
//   pending_i : per-channel pending request
//   last_i    : last granted channel
//   pick_o    : selected channel (0 when nothing is pending)
//   any_o     : at least one channel is pending
// -----------------------------------------------------------------------------
module jt6295_rr_pick (
    input  logic [3:0] pending_i,
    input  logic [1:0] last_i,
    output logic [1:0] pick_o,
    output logic       any_o
);

    logic [1:0] idx;

    always_comb begin
        pick_o = 2'd0;
        any_o  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = last_i + 2'(k + 1);
            if (!any_o && pending_i[idx]) begin
                pick_o = idx;
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt6295_rom_arb.sv
// -----------------------------------------------------------------------------
// jt6295_rom_arb
// Shares one external ROM between the JT6295 control block (phrase table)
// and four ADPCM channels. Each requester owns a one-byte cache entry
// (stored address, data, valid); a request that hits its entry is answered
// without touching the ROM.
//
// Requester handshake: a requester holds cs high with a stable address;
// ok is combinational and is high exactly while cs is high, the entry is
// valid and the address equals the stored one. The data output is only
// meaningful while ok is high. Dropping cs, or changing the address, while
// its ROM access is in flight abandons that access.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ctrl_addr/cs    : control block request (10-bit byte address)
//   ctrl_data/ok    : control block response
//   ch_addr/cs      : four packed channel requests (18-bit, ch0 in [17:0])
//   ch_data/ok      : four packed channel responses (ch0 in [7:0])
//   rom_addr/cs     : external ROM request
//   rom_data/ok     : external ROM response
// -----------------------------------------------------------------------------
module jt6295_rom_arb
    import jt6295_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           ctrl_addr,
    input  logic                 ctrl_cs,
    output logic [7:0]           ctrl_data,
    output logic                 ctrl_ok,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH-1:0]    ch_cs,
    output logic [NUM_CH*8-1:0]  ch_data,
    output logic [NUM_CH-1:0]    ch_ok,
    output logic [AW-1:0]        rom_addr,
    output logic                 rom_cs,
    input  logic [7:0]           rom_data,
    input  logic                 rom_ok
);

    // ------------------------------------------------------------------
    // Requester view: channels at 0..3, control block at CTRL_IDX
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0][AW-1:0] req_addr;
    logic [NUM_REQ-1:0]         req_cs;
    logic [NUM_REQ-1:0]         req_ok;
    logic [NUM_REQ-1:0]         req_pend;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_addr[i] = ch_addr[i*AW +: AW];
            req_cs[i]   = ch_cs[i];
        end
        req_addr[CTRL_IDX] = {8'd0, ctrl_addr};
        req_cs[CTRL_IDX]   = ctrl_cs;
    end

    // ------------------------------------------------------------------
    // Per-requester cache entry
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]         valid_q, valid_d;
    logic [NUM_REQ-1:0][AW-1:0] addr_q,  addr_d;
    logic [NUM_REQ-1:0][7:0]    data_q,  data_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ok[i] = req_cs[i] & valid_q[i] & (req_addr[i] == addr_q[i]);
        end
        req_pend = req_cs & ~req_ok;
    end

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    arb_state_t    state_q, state_d;
    req_idx_t      gnt_q, gnt_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]    fetch_q, fetch_d;
    // ptr_q is the channel where the next round-robin search begins.
    logic [1:0]    ptr_q, ptr_d;

    logic [1:0]    rr_last;
    logic [1:0]    rr_pick;
    logic          rr_any;
    req_idx_t      rr_idx;
    logic          gnt_lost;
    logic          commit;

    assign rr_last = ptr_q - 2'd1;
    assign rr_idx  = {1'b0, rr_pick};

    jt6295_rr_pick u_rr_pick (
        .pending_i (req_pend[NUM_CH-1:0]),
        .last_i    (rr_last),
        .pick_o    (rr_pick),
        .any_o     (rr_any)
    );

    // The in-flight access is abandoned when its owner stops asking for
    // exactly the address that was latched at grant time.
    assign gnt_lost = !req_cs[gnt_q] || (req_addr[gnt_q] != rom_addr_q);

    // The fetched byte is committed to the requester's entry in DONE, so
    // ok rises on the cycle after DONE.
    assign commit = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rom_addr_d = rom_addr_q;
        fetch_d    = fetch_q;
        ptr_d      = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_pend[CTRL_IDX]) begin
                    // Control block wins; the channel pointer is untouched.
                    gnt_d      = CTRL_IDX;
                    rom_addr_d = req_addr[CTRL_IDX];
                    state_d    = ST_ISSUE;
                end else if (rr_any) begin
                    gnt_d      = rr_idx;
                    rom_addr_d = req_addr[rr_idx];
                    ptr_d      = next_ch(rr_pick);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // rom_ok still reflects the previous address here.
                if (gnt_lost) state_d = ST_IDLE;
                else          state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gnt_lost) begin
                    state_d = ST_IDLE;
                end else if (rom_ok) begin
                    fetch_d = rom_data;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (commit && (gnt_q == req_idx_t'(i))) begin
                data_d[i]  = fetch_q;
                addr_d[i]  = rom_addr_q;
                valid_d[i] = req_cs[i];
            end else if (!req_cs[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            rom_addr_q <= '0;
            fetch_q    <= '0;
            ptr_q      <= 2'd0;
            valid_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rom_addr_q <= rom_addr_d;
            fetch_q    <= fetch_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_cs   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign rom_addr = rom_addr_q;

    assign ctrl_data = data_q[CTRL_IDX];
    assign ctrl_ok   = req_ok[CTRL_IDX];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i*8 +: 8] = data_q[i];
        end
    end

    assign ch_ok = req_ok[NUM_CH-1:0];

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// -----------------------------------------------------------------------------
// tb_jt6295_rom_arb
// Directed scenarios followed by randomized rounds for jt6295_rom_arb.
// The reference model keeps, per requester, the last fetched address/data
// and whether the entry is live, and predicts the service order from the
// arbitration rules: control block first, then channels round-robin from
// the channel after the last one served.
// -----------------------------------------------------------------------------
module tb_jt6295_rom_arb;
    import jt6295_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ctrl_addr;
    logic        ctrl_cs;
    logic [7:0]  ctrl_data;
    logic        ctrl_ok;
    logic [71:0] ch_addr;
    logic [3:0]  ch_cs;
    logic [31:0] ch_data;
    logic [3:0]  ch_ok;

    jt6295_rom_arb_if rom_if ();

    always #5 clk = ~clk;

    jt6295_rom_arb dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_addr (ctrl_addr),
        .ctrl_cs   (ctrl_cs),
        .ctrl_data (ctrl_data),
        .ctrl_ok   (ctrl_ok),
        .ch_addr   (ch_addr),
        .ch_cs     (ch_cs),
        .ch_data   (ch_data),
        .ch_ok     (ch_ok),
        .rom_addr  (rom_if.rom_addr),
        .rom_cs    (rom_if.rom_cs),
        .rom_data  (rom_if.rom_data),
        .rom_ok    (rom_if.rom_ok)
    );

    // ---------------- ROM responder ----------------
    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h5A;
    endfunction

    int   rom_mode = 1;   // 0: rom_ok low, 1: rom_ok high, 2: random
    logic rom_ok_r;

    assign rom_if.rom_data = rom_byte(rom_if.rom_addr);
    assign rom_if.rom_ok   = rom_ok_r;

    initial begin
        rom_ok_r = 1'b0;
        forever begin
            @(negedge clk);
            if (rom_mode == 1)      rom_ok_r = 1'b1;
            else if (rom_mode == 2) rom_ok_r = 1'($urandom_range(0, 1));
            else                    rom_ok_r = 1'b0;
        end
    end

    // ---------------- requests and reference model ----------------
    logic [17:0] r_addr [5];
    bit          r_cs   [5];
    bit          m_valid[5];
    logic [17:0] m_addr [5];
    logic [7:0]  m_data [5];
    int          m_ptr;
    logic [17:0] served_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            ch_addr[i*18 +: 18] = r_addr[i];
            ch_cs[i]            = r_cs[i];
        end
        ctrl_addr = r_addr[4][9:0];
        ctrl_cs   = r_cs[4];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
            m_data[i]  = '0;
        end
        m_ptr = 0;
    endtask

    task automatic model_fill(input int e);
        m_valid[e] = 1'b1;
        m_addr[e]  = r_addr[e];
        m_data[e]  = rom_byte(r_addr[e]);
        if (e < 4) m_ptr = (e + 1) % 4;
    endtask

    task automatic wait_cs(output bit good);
        good = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (rom_if.rom_cs === 1'b1) begin
                good = 1'b1;
                break;
            end
        end
    endtask

    // Waits for one ROM access to start and finish; returns its address.
    task automatic serve_one(output logic [17:0] a, output bit good);
        bit held;
        a = '0;
        wait_cs(good);
        if (!good) return;
        a    = rom_if.rom_addr;
        held = 1'b1;
        good = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (rom_if.rom_cs !== 1'b1) begin
                good = 1'b1;
                break;
            end
            if (rom_if.rom_addr !== a) held = 1'b0;
        end
        chk("rom_addr_held", 32'(held), 32'd1);
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0]  eok;
        logic [31:0] ed;
        for (int i = 0; i < 4; i++) begin
            eok[i]        = r_cs[i] && m_valid[i] && (m_addr[i] == r_addr[i]);
            ed[i*8 +: 8]  = m_data[i];
        end
        chk({tag, "_ch_ok"}, 32'(ch_ok), 32'(eok));
        chk({tag, "_ch_data"}, ch_data, ed);
        chk({tag, "_ctrl_ok"}, 32'(ctrl_ok),
            32'(r_cs[4] && m_valid[4] && (m_addr[4] == r_addr[4])));
        chk({tag, "_ctrl_data"}, 32'(ctrl_data), 32'(m_data[4]));
    endtask

    // Serves every pending requester in model order, then checks outputs.
    task automatic run_round(input string tag);
        bit          pend[5];
        int          e;
        logic [17:0] a;
        bit          good;
        for (int i = 0; i < 5; i++) begin
            if (!r_cs[i]) m_valid[i] = 1'b0;
            pend[i] = r_cs[i] && !(m_valid[i] && (m_addr[i] == r_addr[i]));
        end
        apply();
        served_q.delete();
        while (1) begin
            e = -1;
            if (pend[4]) e = 4;
            else begin
                for (int k = 0; k < 4; k++) begin
                    if (e < 0 && pend[(m_ptr + k) % 4]) e = (m_ptr + k) % 4;
                end
            end
            if (e < 0) break;
            serve_one(a, good);
            chk({tag, "_served"}, 32'(good), 32'd1);
            if (!good) break;
            chk({tag, "_grant_addr"}, 32'(a), 32'(r_addr[e]));
            served_q.push_back(a);
            pend[e] = 1'b0;
            model_fill(e);
        end
        tick();
        tick();
        chk({tag, "_idle_cs"}, 32'(rom_if.rom_cs), 32'd0);
        check_outputs(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed steps then random rounds ----------------
    initial begin
        logic [17:0] a;
        bit          good;
        bit          seen;

        // Reset with every requester asking: outputs must stay quiet.
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            r_cs[i]   = 1'b1;
            r_addr[i] = 18'(i * 18'h101 + 18'h10);
        end
        apply();
        repeat (3) tick();
        chk("reset_rom_cs", 32'(rom_if.rom_cs), 32'd0);
        chk("reset_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        chk("reset_ch_ok", 32'(ch_ok), 32'd0);
        chk("reset_ctrl_ok", 32'(ctrl_ok), 32'd0);
        chk("reset_ch_data", ch_data, 32'd0);
        chk("reset_ctrl_data", 32'(ctrl_data), 32'd0);
        for (int i = 0; i < 5; i++) r_cs[i] = 1'b0;
        apply();
        rst = 1'b0;
        tick();

        // Control fetch of byte 5 with rom_ok already high: ok at N+4.
        rom_mode  = 1;
        r_cs[4]   = 1'b1;
        r_addr[4] = 18'h5;
        apply();
        tick();
        chk("t028_issue_cs", 32'(rom_if.rom_cs), 32'd1);
        chk("t028_issue_addr", 32'(rom_if.rom_addr), 32'h5);
        chk("t028_ok_n1", 32'(ctrl_ok), 32'd0);
        tick();
        chk("t028_ok_n2", 32'(ctrl_ok), 32'd0);
        tick();
        chk("t028_ok_n3", 32'(ctrl_ok), 32'd0);
        chk("t028_cs_done", 32'(rom_if.rom_cs), 32'd0);
        tick();
        chk("t028_ok_n4", 32'(ctrl_ok), 32'd1);
        chk("t028_data", 32'(ctrl_data), 32'(rom_byte(18'h5)));
        model_fill(4);

        // Make ch2 the last channel served, then all four ask at once.
        r_cs[2]   = 1'b1;
        r_addr[2] = 18'h2_0040;
        run_round("t029_pre");
        r_addr[0] = 18'h1_2345;
        r_addr[1] = 18'h0_ABCD;
        r_addr[2] = 18'h3_F00F;
        r_addr[3] = 18'h0_0777;
        for (int i = 0; i < 4; i++) r_cs[i] = 1'b1;
        run_round("t029");
        chk("t029_count", 32'(served_q.size()), 32'd4);
        chk("t029_first_ch3", (served_q.size() > 0) ? 32'(served_q[0]) : 32'hDEADBEEF, 32'(r_addr[3]));
        chk("t029_second_ch0", (served_q.size() > 1) ? 32'(served_q[1]) : 32'hDEADBEEF, 32'(r_addr[0]));
        chk("t029_third_ch1", (served_q.size() > 2) ? 32'(served_q[2]) : 32'hDEADBEEF, 32'(r_addr[1]));
        chk("t029_fourth_ch2", (served_q.size() > 3) ? 32'(served_q[3]) : 32'hDEADBEEF, 32'(r_addr[2]));

        // ch0 keeps reading 18'h1_2345: hit, no ROM traffic.
        chk("t031_hit_ok", 32'(ch_ok[0]), 32'd1);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (rom_if.rom_cs !== 1'b0) seen = 1'b1;
        end
        chk("t031_no_rom_cs", 32'(seen), 32'd0);
        chk("t031_hit_data", 32'(ch_data[7:0]), 32'(rom_byte(18'h1_2345)));

        // ctrl and ch1 start asking for new bytes in the same cycle.
        r_addr[4] = 18'h3A;
        r_addr[1] = 18'h1_1111;
        apply();
        serve_one(a, good);
        chk("t030_first_served", 32'(good), 32'd1);
        chk("t030_first_is_ctrl", 32'(a), 32'h3A);
        chk("t030_ch1_ok_after_ctrl", 32'(ch_ok[1]), 32'd0);
        model_fill(4);
        tick();
        chk("t030_ctrl_ok", 32'(ctrl_ok), 32'd1);
        chk("t030_ch1_ok_idle", 32'(ch_ok[1]), 32'd0);
        serve_one(a, good);
        chk("t030_second_is_ch1", 32'(a), 32'(r_addr[1]));
        chk("t030_ch1_ok_in_done", 32'(ch_ok[1]), 32'd0);
        model_fill(1);
        tick();
        check_outputs("t030");

        // ch2 moves its address while its access waits on the ROM.
        rom_mode  = 0;
        r_addr[2] = 18'h2_AAAA;
        apply();
        wait_cs(good);
        chk("t032_issue", 32'(good), 32'd1);
        chk("t032_issue_addr", 32'(rom_if.rom_addr), 32'h2_AAAA);
        tick();
        chk("t032_wait_cs", 32'(rom_if.rom_cs), 32'd1);
        r_addr[2] = 18'h2_5555;
        apply();
        tick();
        chk("t032_abort_cs", 32'(rom_if.rom_cs), 32'd0);
        chk("t032_abort_ok", 32'(ch_ok[2]), 32'd0);
        chk("t032_no_capture", 32'(ch_data[23:16]), 32'(m_data[2]));
        rom_mode = 1;
        serve_one(a, good);
        chk("t032_refetch_addr", 32'(a), 32'h2_5555);
        model_fill(2);
        tick();
        check_outputs("t032");

        // Reset lands while ch3 waits on the ROM.
        rom_mode  = 0;
        r_addr[3] = 18'h0_3333;
        apply();
        wait_cs(good);
        chk("t033_issue", 32'(good), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("t033_rst_cs", 32'(rom_if.rom_cs), 32'd0);
        chk("t033_rst_ch_ok", 32'(ch_ok), 32'd0);
        chk("t033_rst_ctrl_ok", 32'(ctrl_ok), 32'd0);
        r_cs[4] = 1'b0;
        for (int i = 0; i < 4; i++) r_addr[i] = 18'(18'h0_4000 + i * 18'h111);
        apply();
        model_reset();
        rom_mode = 1;
        rst = 1'b0;
        run_round("t033");
        chk("t033_first_ch0", (served_q.size() > 0) ? 32'(served_q[0]) : 32'hDEADBEEF, 32'(r_addr[0]));

        // Random rounds: mixed hits, misses, idle requesters, jittery ROM.
        rom_mode = 2;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 5; i++) begin
                r_cs[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    if (i == 4) r_addr[i] = 18'($urandom_range(0, 1023));
                    else        r_addr[i] = 18'($urandom_range(0, 262143));
                end
            end
            run_round("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
